// File: rtl/pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// pc_gen_pkg
// Shared constants and helpers for the fetch PC generation stage.
//   ADDR_BUS_WIDTH       : fetch address width
//   GHR_WIDTH_DEF        : default global-history length (PHT has 2^N counters)
//   BTB_INDEX_WIDTH_DEF  : default BTB index width (2^N entries)
//   PHT_INIT             : counter value after reset (weakly not-taken)
//   btb_tag_width()      : tag bits left above the index and byte offset
//   pht_next()           : 2-bit saturating counter update
// -----------------------------------------------------------------------------
package pc_gen_pkg;

    localparam int ADDR_BUS_WIDTH      = 32;
    localparam int GHR_WIDTH_DEF       = 5;
    localparam int BTB_INDEX_WIDTH_DEF = 6;
    localparam logic [1:0] PHT_INIT    = 2'b01;

    // Word-aligned fetch: the two byte-offset bits never take part in index or tag.
    function automatic int btb_tag_width(input int index_width);
        return ADDR_BUS_WIDTH - index_width - 2;
    endfunction

    // Saturating 2-bit counter, range 0..3.
    function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        case ({taken, cnt})
            3'b1_11: nxt = 2'b11;
            3'b0_00: nxt = 2'b00;
            3'b1_00, 3'b1_01, 3'b1_10: nxt = cnt + 2'd1;
            3'b0_01, 3'b0_10, 3'b0_11: nxt = cnt - 2'd1;
            default: nxt = PHT_INIT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pc_gen_branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
// Direct-mapped BTB: valid/tag/target arrays with asynchronous read and
// synchronous write. Only the valid bits are reset (async, active-low);
// tag and target contents are meaningless while their valid bit is clear.
// Ports:
//   clk_i, rst_ni            clock / async active-low reset
//   rd_index_i, rd_tag_i     lookup address split
//   hit_o, target_o          combinational lookup result
//   wr_en_i, wr_index_i,
//   wr_tag_i, wr_target_i    allocate/overwrite one entry
// A write and a read of the same entry in one cycle return the old contents.
// -----------------------------------------------------------------------------
module branch_target_buffer
    import pc_gen_pkg::*;
#(
    parameter int INDEX_WIDTH = BTB_INDEX_WIDTH_DEF,
    parameter int TAG_WIDTH   = 24,
    parameter int DATA_WIDTH  = ADDR_BUS_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [INDEX_WIDTH-1:0] rd_index_i,
    input  logic [TAG_WIDTH-1:0]   rd_tag_i,
    output logic                   hit_o,
    output logic [DATA_WIDTH-1:0]  target_o,
    input  logic                   wr_en_i,
    input  logic [INDEX_WIDTH-1:0] wr_index_i,
    input  logic [TAG_WIDTH-1:0]   wr_tag_i,
    input  logic [DATA_WIDTH-1:0]  wr_target_i
);

    localparam int ENTRIES = 32'd1 << INDEX_WIDTH;

    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [ENTRIES];

    assign hit_o    = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
    assign target_o = target_q[rd_index_i];

    // Valid bits: cleared by reset, set on allocation, never invalidated.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag/target storage: plain write port, no reset needed.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]    <= wr_tag_i;
            target_q[wr_index_i] <= wr_target_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Fetch PC generation stage. Holds the fetch PC and, when the predictor is
// built in, predicts the next PC with a gshare PHT plus a direct-mapped BTB.
// Build option: define PCGEN_BRANCH_PRED_EN to include PHT, BTB and both
// history registers; without it the stage is flush/redirect/hold/pc+4 only,
// the prediction output is 0 and the update port is ignored.
// Ports:
//   clk, rst (async active-low)
//   flush/flush_pc           highest-priority PC load (exception/eret)
//   redirect_en/redirect_pc  mispredict recovery from execute
//   stall_current_stage      hold PC and speculative history
//   update_*                 resolved-branch training port
//   pc_out                   current fetch PC
//   is_branch_taken_out      prediction for pc_out
//   pht_index_out            pc_out[GHR_WIDTH+1:2] ^ speculative history
// Outputs are the registered PC plus combinational lookup (no output flops).
// -----------------------------------------------------------------------------
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int GHR_WIDTH                     = GHR_WIDTH_DEF,
    parameter int BTB_INDEX_WIDTH               = BTB_INDEX_WIDTH_DEF,
    parameter logic [ADDR_BUS_WIDTH-1:0] RESET_PC = 32'hbfc00000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [ADDR_BUS_WIDTH-1:0] flush_pc,
    input  logic                      redirect_en,
    input  logic [ADDR_BUS_WIDTH-1:0] redirect_pc,
    input  logic                      stall_current_stage,
    input  logic                      update_en,
    input  logic [ADDR_BUS_WIDTH-1:0] update_pc,
    input  logic                      update_is_taken,
    input  logic [ADDR_BUS_WIDTH-1:0] update_target,
    input  logic [GHR_WIDTH-1:0]      update_pht_index,
    output logic [ADDR_BUS_WIDTH-1:0] pc_out,
    output logic                      is_branch_taken_out,
    output logic [GHR_WIDTH-1:0]      pht_index_out
);

    logic [ADDR_BUS_WIDTH-1:0] pc_q;
    logic [ADDR_BUS_WIDTH-1:0] pc_d;
    logic                      pred_taken_s;
    logic [ADDR_BUS_WIDTH-1:0] pred_target_s;
    logic [GHR_WIDTH-1:0]      pht_index_s;
    logic                      unused_s;

`ifdef PCGEN_BRANCH_PRED_EN
    localparam int PHT_ENTRIES   = 32'd1 << GHR_WIDTH;
    localparam int BTB_TAG_WIDTH = btb_tag_width(BTB_INDEX_WIDTH);

    logic [GHR_WIDTH-1:0]      spec_ghr_q;
    logic [GHR_WIDTH-1:0]      spec_ghr_d;
    logic [GHR_WIDTH-1:0]      cmt_ghr_q;
    logic [GHR_WIDTH-1:0]      cmt_ghr_d;
    logic [GHR_WIDTH-1:0]      cmt_shift_s;
    logic [1:0]                pht_q [PHT_ENTRIES];
    logic                      btb_hit_s;
    logic [ADDR_BUS_WIDTH-1:0] btb_target_s;

    branch_target_buffer #(
        .INDEX_WIDTH (BTB_INDEX_WIDTH),
        .TAG_WIDTH   (BTB_TAG_WIDTH),
        .DATA_WIDTH  (ADDR_BUS_WIDTH)
    ) u_btb (
        .clk_i       (clk),
        .rst_ni      (rst),
        .rd_index_i  (pc_q[BTB_INDEX_WIDTH+1:2]),
        .rd_tag_i    (pc_q[ADDR_BUS_WIDTH-1:BTB_INDEX_WIDTH+2]),
        .hit_o       (btb_hit_s),
        .target_o    (btb_target_s),
        .wr_en_i     (update_en & update_is_taken),
        .wr_index_i  (update_pc[BTB_INDEX_WIDTH+1:2]),
        .wr_tag_i    (update_pc[ADDR_BUS_WIDTH-1:BTB_INDEX_WIDTH+2]),
        .wr_target_i (update_target)
    );

    assign pht_index_s   = pc_q[GHR_WIDTH+1:2] ^ spec_ghr_q;
    assign pred_taken_s  = btb_hit_s & pht_q[pht_index_s][1];
    assign pred_target_s = btb_target_s;
    assign cmt_shift_s   = {cmt_ghr_q[GHR_WIDTH-2:0], update_is_taken};
    assign unused_s      = ^update_pc[1:0];

    // History next-state: committed history follows resolved branches;
    // speculative history shifts on predicted branches and is rebuilt from
    // the (possibly just-updated) committed history on flush/redirect.
    always_comb begin
        cmt_ghr_d  = cmt_ghr_q;
        spec_ghr_d = spec_ghr_q;
        if (update_en) begin
            cmt_ghr_d = cmt_shift_s;
        end else begin
            cmt_ghr_d = cmt_ghr_q;
        end
        if (flush || redirect_en) begin
            spec_ghr_d = cmt_ghr_d;
        end else if (!stall_current_stage && btb_hit_s) begin
            spec_ghr_d = {spec_ghr_q[GHR_WIDTH-2:0], pred_taken_s};
        end else begin
            spec_ghr_d = spec_ghr_q;
        end
    end

    // History registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spec_ghr_q <= '0;
            cmt_ghr_q  <= '0;
        end else begin
            spec_ghr_q <= spec_ghr_d;
            cmt_ghr_q  <= cmt_ghr_d;
        end
    end

    // PHT training; the lookup in the same cycle still sees the old counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= PHT_INIT;
            end
        end else if (update_en) begin
            pht_q[update_pht_index] <= pht_next(pht_q[update_pht_index], update_is_taken);
        end
    end
`else
    assign pht_index_s   = pc_q[GHR_WIDTH+1:2];
    assign pred_taken_s  = 1'b0;
    assign pred_target_s = '0;
    assign unused_s      = ^{update_en, update_pc, update_is_taken,
                             update_target, update_pht_index};
`endif

    // Next-PC select: flush > redirect > stall > predicted target > pc+4.
    always_comb begin
        pc_d = pc_q;
        if (flush) begin
            pc_d = flush_pc;
        end else if (redirect_en) begin
            pc_d = redirect_pc;
        end else if (stall_current_stage) begin
            pc_d = pc_q;
        end else if (pred_taken_s) begin
            pc_d = pred_target_s;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out              = pc_q;
    assign is_branch_taken_out = pred_taken_s;
    assign pht_index_out       = pht_index_s;

endmodule
